fp16_add_sequencer: RTL and testbench

Multi-cycle sequencer for half-precision floating-point addition, built around one shared 11-bit mantissa add/subtract datapath (hidden bit plus 10 fraction bits).
- Accepts one operand pair per transaction over a valid/ready handshake.
- Steps through swap, alignment, add, normalise and (optionally) round.
- Presents the packed result on a valid/ready output.
- Sits between the FP operand source and the result consumer in the FloatingPointOperations/Addition datapath.

---
 rtl/fp16_add_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fp16_add_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_add_sequencer.sv
// fp16_add_sequencer
//   Multi-cycle half-precision adder built around one shared mantissa
//   add/subtract datapath. One operand pair is accepted per transaction;
//   the sequencer steps through alignment, add and normalise, then holds
//   the packed result until the consumer takes it. Subnormal inputs are
//   flushed to zero. Results are truncated toward zero unless the
//   FPADD_RNE_EN macro is defined, in which case guard/round/sticky bits
//   are carried and a ROUND state applies round-to-nearest-even.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   sequencer can accept (IDLE only)
//   a, b       operands {sign, exp, frac}
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   result     packed sum
//   ovf        result saturated to infinity
//   uflow      result flushed to zero by underflow
module fp16_add_sequencer #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   ovf,
    output logic                   uflow
);
`ifdef FPADD_RNE_EN
    localparam int GRS = 3;
`else
    localparam int GRS = 0;
`endif
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int M = MAN_W + 1 + GRS;
    localparam logic [4:0]       DMAX   = 5'(MAN_W + 2);
    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [EXP_W-1:0] E_ONE  = EXP_W'(1);
    localparam logic [MAN_W-1:0] F_ZERO = '0;
    localparam logic [W-1:0]     QNAN   = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
    state_t state, state_d;

    logic             sign_q, sub_q, carry_q, ovf_q, uflow_q;
    logic [EXP_W-1:0] exp_q;
    logic [M-1:0]     ma, mb;
    logic [4:0]       cnt;
    logic [W-1:0]     result_q;

    // Operand decode and swap
    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_big, special, s_big;
    logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff;
    logic [MAN_W-1:0] fa, fb, f_big, f_sml;
    logic [4:0]       dp;
    logic [W-1:0]     special_res;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_inf   = (ea == E_ONES);
        b_inf   = (eb == E_ONES);
        special = a_zero | b_zero | a_inf | b_inf;
        a_big   = ({ea, fa} >= {eb, fb});
        s_big   = a_big ? sa : sb;
        e_big   = a_big ? ea : eb;
        f_big   = a_big ? fa : fb;
        e_sml   = a_big ? eb : ea;
        f_sml   = a_big ? fb : fa;
        diff    = e_big - e_sml;
        dp      = (diff > EXP_W'(MAN_W + 2)) ? DMAX : 5'(diff);

        special_res = '0;
        if (a_inf && b_inf && (sa != sb)) special_res = QNAN;
        else if (a_inf)                   special_res = {sa, E_ONES, F_ZERO};
        else if (b_inf)                   special_res = {sb, E_ONES, F_ZERO};
        else if (a_zero && b_zero)        special_res = {sa & sb, {(W-1){1'b0}}};
        else if (a_zero)                  special_res = b;
        else                              special_res = a;
    end

    // One alignment step; with rounding enabled the LSB is sticky.
    logic [M-1:0] mb_sh;
    always_comb begin
        mb_sh = mb >> 1;
`ifdef FPADD_RNE_EN
        mb_sh[0] = mb[1] | mb[0];
`endif
    end

    // One normalisation step.
    logic [M-1:0]     nm;
    logic [EXP_W-1:0] ne;
    logic             n_fin, n_ovf, n_unf, n_zero;
    always_comb begin
        nm     = ma;
        ne     = exp_q;
        n_fin  = 1'b0;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        n_zero = 1'b0;
        if (carry_q) begin
            nm    = {1'b1, ma[M-1:1]};
`ifdef FPADD_RNE_EN
            nm[0] = ma[1] | ma[0];
`endif
            ne    = exp_q + E_ONE;
            n_fin = 1'b1;
            n_ovf = (exp_q == E_ONES - E_ONE);
        end else if (ma == '0) begin
            n_fin  = 1'b1;
            n_zero = 1'b1;
        end else if (!ma[M-1]) begin
            if (exp_q == E_ONE) begin
                n_fin = 1'b1;
                n_unf = 1'b1;
            end else begin
                nm = ma << 1;
                ne = exp_q - E_ONE;
            end
        end else begin
            n_fin = 1'b1;
        end
    end

`ifdef FPADD_RNE_EN
    // Round-to-nearest-even on the guard/round/sticky tail.
    logic           rnd_up;
    logic [MAN_W+1:0] rsum;
    always_comb begin
        rnd_up = ma[2] & (ma[1] | ma[0] | ma[3]);
        rsum   = {1'b0, ma[M-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    end
`endif

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state;
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        case (state)
            S_IDLE:  if (in_valid) state_d = special ? S_DONE : ((dp != '0) ? S_ALIGN : S_ADD);
            S_ALIGN: if (cnt == 5'd1) state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
`ifdef FPADD_RNE_EN
            S_NORM:  if (n_fin) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
`else
            S_NORM:  if (n_fin) state_d = S_DONE;
`endif
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            exp_q    <= '0;
            ma       <= '0;
            mb       <= '0;
            cnt      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    ovf_q   <= 1'b0;
                    uflow_q <= 1'b0;
                    carry_q <= 1'b0;
                    if (special) begin
                        result_q <= special_res;
                    end else begin
                        sign_q <= s_big;
                        sub_q  <= sa ^ sb;
                        exp_q  <= e_big;
                        cnt    <= dp;
                        ma     <= M'({1'b1, f_big}) << GRS;
                        // A shift past every datapath bit leaves nothing of B.
                        mb     <= (dp == DMAX) ? '0 : (M'({1'b1, f_sml}) << GRS);
                    end
                end
                S_ALIGN: begin
                    mb  <= mb_sh;
                    cnt <= cnt - 5'd1;
                end
                S_ADD: begin
                    // The swap guarantees ma >= mb, so subtraction never goes negative.
                    if (sub_q) begin
                        ma      <= ma - mb;
                        carry_q <= 1'b0;
                    end else begin
                        {carry_q, ma} <= {1'b0, ma} + {1'b0, mb};
                    end
                end
                S_NORM: begin
                    ma    <= nm;
                    exp_q <= ne;
                    if (n_ovf) begin
                        result_q <= {sign_q, E_ONES, F_ZERO};
                        ovf_q    <= 1'b1;
                    end else if (n_unf) begin
                        result_q <= {sign_q, {(W-1){1'b0}}};
                        uflow_q  <= 1'b1;
                    end else if (n_zero) begin
                        result_q <= '0;
`ifndef FPADD_RNE_EN
                    end else if (n_fin) begin
                        result_q <= {sign_q, ne, nm[M-2:0]};
`endif
                    end
                end
`ifdef FPADD_RNE_EN
                S_ROUND: begin
                    // Zero, underflow and overflow results were already fixed in NORM.
                    if (ma[M-1] && !ovf_q) begin
                        if (rsum[MAN_W+1]) begin
                            if (exp_q == E_ONES - E_ONE) begin
                                result_q <= {sign_q, E_ONES, F_ZERO};
                                ovf_q    <= 1'b1;
                            end else begin
                                result_q <= {sign_q, exp_q + E_ONE, rsum[MAN_W:1]};
                            end
                        end else begin
                            result_q <= {sign_q, exp_q, rsum[MAN_W-1:0]};
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign ovf    = ovf_q;
    assign uflow  = uflow_q;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// Self-checking bench for fp16_add_sequencer: directed cases followed by
// randomized operand pairs, all compared against an integer-arithmetic
// reference model of the addition rules.
module tb_fp16_add_sequencer;
`ifdef FPADD_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        ovf;
    logic        uflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] last_res;
    logic        last_ovf, last_uflow;
    int          last_lat;

    fp16_add_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .uflow     (uflow)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model. lat = clock edges after the accept edge until out_valid
    // is high (0 for the special-case shortcut, which is valid straight away).
    function automatic void ref_add(input logic [15:0] x, input logic [15:0] y,
                                    output logic [15:0] r, output logic o, output logic u,
                                    output int lat);
        logic sx, sy, sg, fixed;
        int   ex, ey, fx, fy, e, es, mbig, msml, d, dp, lost, m, mant, xb;
        xb = RNE ? 3 : 0;
        o = 1'b0; u = 1'b0; lat = 0; fixed = 1'b0; r = '0;
        sx = x[15]; sy = y[15];
        ex = int'(x[14:10]); ey = int'(y[14:10]);
        fx = int'(x[9:0]);   fy = int'(y[9:0]);
        if (ex == 31 || ey == 31) begin
            if (ex == 31 && ey == 31 && sx != sy) r = 16'h7E00;
            else if (ex == 31)                    r = {sx, 5'h1f, 10'h0};
            else                                  r = {sy, 5'h1f, 10'h0};
            return;
        end
        if (ex == 0 && ey == 0) begin r = {sx & sy, 15'h0}; return; end
        if (ex == 0) begin r = y; return; end
        if (ey == 0) begin r = x; return; end
        if (x[14:0] >= y[14:0]) begin sg = sx; e = ex; mbig = fx; es = ey; msml = fy; end
        else                    begin sg = sy; e = ey; mbig = fy; es = ex; msml = fx; end
        mbig = (1024 + mbig) << xb;
        msml = (1024 + msml) << xb;
        d  = e - es;
        dp = (d > 12) ? 12 : d;
        if (dp == 12) msml = 0;
        else begin
            lost = msml & ((1 << dp) - 1);
            msml = msml >> dp;
            if (RNE && lost != 0) msml = msml | 1;
        end
        lat = dp + 2;                       // alignment, add, final normalise cycle
        m = (sx == sy) ? mbig + msml : mbig - msml;
        if (m >= (2048 << xb)) begin
            lost = m & 1;
            m = m >> 1;
            if (RNE && lost != 0) m = m | 1;
            e++;
            if (e == 31) begin o = 1'b1; r = {sg, 5'h1f, 10'h0}; fixed = 1'b1; end
        end else if (m == 0) begin
            r = '0; fixed = 1'b1;
        end else begin
            while (!fixed && m < (1024 << xb)) begin
                if (e == 1) begin u = 1'b1; r = {sg, 15'h0}; fixed = 1'b1; end
                else begin m = m << 1; e--; lat++; end
            end
        end
        if (RNE) lat++;
        if (!fixed) begin
            mant = m >> xb;
            if (RNE && ((m & 4) != 0) && (((m & 3) != 0) || ((mant & 1) != 0))) mant++;
            if (mant == 2048) begin
                mant = 1024;
                e++;
                if (e == 31) o = 1'b1;
            end
            r = o ? {sg, 5'h1f, 10'h0} : {sg, 5'(e), 10'(mant)};
        end
    endfunction

    // One transaction; hold > 0 keeps out_ready low for that many cycles in DONE.
    task automatic txn(input logic [15:0] ta, input logic [15:0] tb, input int hold, input string tag);
        logic [15:0] er, held;
        logic        eo, eu;
        int          el, n;
        ref_add(ta, tb, er, eo, eu, el);
        check({31'b0, in_ready}, 32'd1, {tag, "/idle_ready"});
        a = ta; b = tb; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        last_res = result; last_ovf = ovf; last_uflow = uflow; last_lat = n;
        check(32'(n), 32'(el), {tag, "/latency"});
        check({31'b0, out_valid}, 32'd1, {tag, "/out_valid"});
        check({16'b0, result}, {16'b0, er}, {tag, "/result"});
        check({31'b0, ovf}, {31'b0, eo}, {tag, "/ovf"});
        check({31'b0, uflow}, {31'b0, eu}, {tag, "/uflow"});
        if (hold > 0) begin
            held = result;
            a = ~ta; b = tb; in_valid = 1'b1;   // must be ignored while busy
            repeat (hold) begin
                @(posedge clk); #1;
                check({31'b0, out_valid}, 32'd1, {tag, "/hold_valid"});
                check({31'b0, in_ready}, 32'd0, {tag, "/hold_ready"});
                check({16'b0, result}, {16'b0, held}, {tag, "/hold_result"});
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({31'b0, out_valid}, 32'd0, {tag, "/drained"});
        check({31'b0, in_ready}, 32'd1, {tag, "/back_idle"});
    endtask

    initial begin
        int seen;
        #12;
        check({31'b0, in_ready}, 32'd1, "reset/in_ready");
        check({31'b0, out_valid}, 32'd0, "reset/out_valid");
        check({16'b0, result}, 32'd0, "reset/result");
        check({30'b0, ovf, uflow}, 32'd0, "reset/flags");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.0 + 1.0
        txn(16'h3C00, 16'h3C00, 0, "one_plus_one");
        check({16'b0, last_res}, 32'h4000, "one_plus_one/const");
        check(32'(last_lat), RNE ? 32'd3 : 32'd2, "one_plus_one/lat_const");
        // 1.0 + (-1.0): exact cancellation
        txn(16'h3C00, 16'hBC00, 0, "cancel");
        check({15'b0, last_uflow, last_res}, 32'h0, "cancel/const");
        // 1.0 + 1.5 x 2^-11: alignment distance 11
        txn(16'h3C00, 16'h1200, 0, "far_align");
        check({16'b0, last_res}, RNE ? 32'h3C01 : 32'h3C00, "far_align/const");
        check(32'(last_lat), RNE ? 32'd14 : 32'd13, "far_align/lat_const");
        txn(16'h3C00, 16'h1600, 0, "align10");
        // Largest normal doubled saturates
        txn(16'h7BFF, 16'h7BFF, 0, "max_sum");
        check({15'b0, last_ovf, last_res}, 32'h17C00, "max_sum/const");
        // Specials and flush cases
        txn(16'h7C00, 16'hFC00, 0, "inf_minus_inf");
        check({16'b0, last_res}, 32'h7E00, "inf_minus_inf/const");
        txn(16'h8000, 16'h8000, 0, "neg_zeros");
        txn(16'h0123, 16'hC500, 0, "subnormal_flush");
        txn(16'h0400, 16'h8401, 0, "underflow");
        // Backpressure in DONE
        txn(16'h4200, 16'hC000, 5, "backpressure");

        // Reset while aligning abandons the transaction
        a = 16'h3C00; b = 16'h1400; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({31'b0, in_ready}, 32'd0, "rst_mid/busy");
        rst_n = 1'b0; #1;
        check({31'b0, in_ready}, 32'd1, "rst_mid/in_ready");
        check({31'b0, out_valid}, 32'd0, "rst_mid/out_valid");
        check({16'b0, result}, 32'd0, "rst_mid/result");
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(32'(seen), 32'd0, "rst_mid/no_result");

        for (int i = 0; i < 250; i++) begin
            int ea_i, eb_i, sel;
            logic [15:0] ta, tb;
            ea_i = (i % 10 == 0) ? 30 : int'($urandom_range(1, 30));
            ta = {1'($urandom_range(0, 1)), 5'(ea_i), 10'($urandom)};
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: tb = {~ta[15], ta[14:3], 3'($urandom)};
                1: tb = {1'($urandom_range(0, 1)), 5'd0, 10'($urandom)};
                2: tb = {1'($urandom_range(0, 1)), 5'h1f, 10'($urandom)};
                3: begin
                    eb_i = ea_i - int'($urandom_range(0, 15));
                    if (eb_i < 1) eb_i = 1;
                    tb = {1'($urandom_range(0, 1)), 5'(eb_i), 10'($urandom)};
                end
                default: begin
                    eb_i = ea_i + int'($urandom_range(0, 4)) - 2;
                    if (eb_i < 1) eb_i = 1;
                    if (eb_i > 30) eb_i = 30;
                    tb = {1'($urandom_range(0, 1)), 5'(eb_i), 10'($urandom)};
                end
            endcase
            if ($urandom_range(0, 1) == 1) txn(tb, ta, 0, "rand");
            else                           txn(ta, tb, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
